lpddr3_dqsw_training_ctrl: RTL

- Fabric-side training engine for one DQSW270 lane IOD in the LPDDR3 PHY.
- Drives the IOD delay-line controls (MOVE/DIRECTION/LOAD) and eye-monitor flag clear.
- Consumes the IOD EYE_MONITOR_EARLY/LATE and DELAY_LINE_OUT_OF_RANGE flags.
- Sweeps taps upward from 0, finds the first contiguous passing window, then steps the delay line back to the window centre and reports the edges.

---
 rtl/lpddr3_dqsw_train_pkg.sv | 26 ++
 rtl/lpddr3_dqsw_eye_sampler.sv | 59 +++++
 rtl/lpddr3_dqsw_training_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/lpddr3_dqsw_train_pkg.sv
// Shared types and default parameters for the LPDDR3 DQSW270 lane training engine.
// Optional build macro used by the top level: DQSW_TRAIN_TAP_MAP_EN (per-tap pass map output).
package lpddr3_dqsw_train_pkg;

  localparam int DEF_NUM_TAPS      = 128;
  localparam int DEF_SETTLE_CYCLES = 8;
  localparam int DEF_SAMPLE_CYCLES = 16;
  localparam int DEF_MIN_WINDOW    = 4;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    SETTLE,
    CLEAR,
    SAMPLE,
    EVAL,
    STEP,
    CHECK,
    CENTER,
    CSETTLE,
    FAIL_RET,
    DONE,
    FAIL
  } train_state_t;

endpackage

// File: rtl/lpddr3_dqsw_eye_sampler.sv
// Settle/sample timer and eye-flag accumulator for the DQSW training engine.
// A start pulse launches either a settle wait (sample_mode=0) or an eye-flag
// accumulation window (sample_mode=1); done is high on the last cycle of the
// window and pass holds the result of the most recent accumulation.
module lpddr3_dqsw_eye_sampler
  import lpddr3_dqsw_train_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic sample_mode,
  input  logic early,
  input  logic late,
  output logic done,
  output logic pass
);

  localparam int MAX_CYC = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic             busy;
  logic             mode_r;
  logic [CNT_W-1:0] cnt;
  logic             err;

  assign done = busy && (cnt == '0);

  // Window activity flag; reset drops any window in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      mode_r <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      mode_r <= sample_mode;
    end else if (done) begin
      busy <= 1'b0;
    end
  end

  // Countdown and early/late OR-accumulation; pass is latched on the final sample cycle.
  always_ff @(posedge clk) begin
    if (start) begin
      cnt <= sample_mode ? CNT_W'(SAMPLE_CYCLES - 1) : CNT_W'(SETTLE_CYCLES - 1);
      err <= 1'b0;
    end else if (busy) begin
      err <= err | (mode_r & (early | late));
      if (cnt == '0) begin
        if (mode_r) pass <= !(err | early | late);
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/lpddr3_dqsw_training_ctrl.sv
// Fabric-side DQSW270 delay-line training engine: sweeps taps upward from 0,
// finds the first contiguous passing eye window, steps back to its centre.
// Optional build macro: DQSW_TRAIN_TAP_MAP_EN adds the TAP_PASS_MAP output.
module lpddr3_dqsw_training_ctrl
  import lpddr3_dqsw_train_pkg::*;
#(
  parameter int NUM_TAPS      = DEF_NUM_TAPS,
  parameter int TAP_W         = $clog2(NUM_TAPS),
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int MIN_WINDOW    = DEF_MIN_WINDOW
) (
  input  logic             FAB_CLK,
  input  logic             SYNC_RST,
  input  logic             TRAIN_START,
  output logic             TRAIN_BUSY,
  output logic             TRAIN_DONE,
  output logic             TRAIN_FAIL,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             DELAY_LINE_LOAD,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  output logic [TAP_W-1:0] LEFT_EDGE,
  output logic [TAP_W-1:0] RIGHT_EDGE,
  output logic [TAP_W-1:0] CENTER_TAP
`ifdef DQSW_TRAIN_TAP_MAP_EN
  ,
  output logic [NUM_TAPS-1:0] TAP_PASS_MAP
`endif
);

  localparam logic [TAP_W-1:0] LAST_TAP  = TAP_W'(NUM_TAPS - 1);
  localparam logic [TAP_W:0]   MIN_WIN_V = (TAP_W + 1)'(MIN_WINDOW);

  train_state_t     state, next_state;
  logic [TAP_W-1:0] tap;
  logic [TAP_W-1:0] remaining;
  logic             found;
  logic             dir_r;
  logic             start_ok;
  logic             center_move;
  logic             window_ok;
  logic [TAP_W:0]   win_w;
  logic [TAP_W-1:0] mid;
  logic             smp_start, smp_mode, smp_done, smp_pass;

  // Floor of the edge average, computed on a one-bit-wider sum so it cannot wrap.
  function automatic logic [TAP_W-1:0] mid_tap(input logic [TAP_W-1:0] a, input logic [TAP_W-1:0] b);
    logic [TAP_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return TAP_W'(s >> 1);
  endfunction

  assign start_ok    = TRAIN_START && (state == IDLE || state == DONE || state == FAIL);
  assign center_move = (state == CENTER) && (remaining != '0);
  assign win_w       = {1'b0, RIGHT_EDGE} - {1'b0, LEFT_EDGE} + (TAP_W + 1)'(1);
  assign window_ok   = found && (win_w >= MIN_WIN_V);
  assign mid         = mid_tap(LEFT_EDGE, RIGHT_EDGE);

  lpddr3_dqsw_eye_sampler #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .SAMPLE_CYCLES (SAMPLE_CYCLES)
  ) u_sampler (
    .clk         (FAB_CLK),
    .rst         (SYNC_RST),
    .start       (smp_start),
    .sample_mode (smp_mode),
    .early       (EYE_MONITOR_EARLY),
    .late        (EYE_MONITOR_LATE),
    .done        (smp_done),
    .pass        (smp_pass)
  );

  // State register.
  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state decode and single-cycle IOD control pulses.
  always_comb begin
    next_state              = state;
    DELAY_LINE_MOVE         = 1'b0;
    DELAY_LINE_DIRECTION    = dir_r;
    DELAY_LINE_LOAD         = 1'b0;
    EYE_MONITOR_CLEAR_FLAGS = 1'b0;
    TRAIN_BUSY              = 1'b1;
    TRAIN_DONE              = 1'b0;
    TRAIN_FAIL              = 1'b0;
    smp_start               = 1'b0;
    smp_mode                = 1'b0;
    case (state)
      IDLE, DONE, FAIL: begin
        TRAIN_BUSY = 1'b0;
        TRAIN_DONE = (state == DONE);
        TRAIN_FAIL = (state == FAIL);
        if (TRAIN_START) next_state = LOAD;
      end
      LOAD: begin
        DELAY_LINE_LOAD = 1'b1;
        smp_start       = 1'b1;
        next_state      = SETTLE;
      end
      SETTLE:  if (smp_done) next_state = CLEAR;
      CLEAR: begin
        EYE_MONITOR_CLEAR_FLAGS = 1'b1;
        smp_start               = 1'b1;
        smp_mode                = 1'b1;
        next_state              = SAMPLE;
      end
      SAMPLE:  if (smp_done) next_state = EVAL;
      EVAL: begin
        if ((!smp_pass && found) || tap == LAST_TAP || DELAY_LINE_OUT_OF_RANGE) next_state = CHECK;
        else                                                                    next_state = STEP;
      end
      STEP: begin
        DELAY_LINE_MOVE      = 1'b1;
        DELAY_LINE_DIRECTION = 1'b1;
        smp_start            = 1'b1;
        next_state           = SETTLE;
      end
      CHECK:   next_state = window_ok ? CENTER : FAIL_RET;
      CENTER: begin
        if (center_move) begin
          DELAY_LINE_MOVE      = 1'b1;
          DELAY_LINE_DIRECTION = 1'b0;
          smp_start            = 1'b1;
          next_state           = CSETTLE;
        end else begin
          next_state = DONE;
        end
      end
      CSETTLE: if (smp_done) next_state = CENTER;
      FAIL_RET: begin
        DELAY_LINE_LOAD = 1'b1;
        next_state      = FAIL;
      end
      default: next_state = IDLE;
    endcase
  end

  // Tap tracking, edge capture and centring arithmetic.
  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      tap        <= '0;
      remaining  <= '0;
      found      <= 1'b0;
      dir_r      <= 1'b0;
      LEFT_EDGE  <= '0;
      RIGHT_EDGE <= '0;
      CENTER_TAP <= '0;
    end else begin
      case (state)
        IDLE, DONE, FAIL: begin
          if (start_ok) begin
            tap        <= '0;
            found      <= 1'b0;
            LEFT_EDGE  <= '0;
            RIGHT_EDGE <= '0;
            CENTER_TAP <= '0;
          end
        end
        EVAL: begin
          if (smp_pass) begin
            if (!found) begin
              LEFT_EDGE <= tap;
              found     <= 1'b1;
            end
            RIGHT_EDGE <= tap;
          end
        end
        STEP: begin
          tap   <= tap + TAP_W'(1);
          dir_r <= 1'b1;
        end
        CHECK: begin
          if (window_ok) begin
            CENTER_TAP <= mid;
            remaining  <= tap - mid;
          end
        end
        CENTER: begin
          if (center_move) begin
            remaining <= remaining - TAP_W'(1);
            tap       <= tap - TAP_W'(1);
            dir_r     <= 1'b0;
          end
        end
        FAIL_RET: CENTER_TAP <= '0;
        default: ;
      endcase
    end
  end

`ifdef DQSW_TRAIN_TAP_MAP_EN
  // Per-tap pass record, rebuilt on every accepted start.
  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST || start_ok)         TAP_PASS_MAP      <= '0;
    else if (state == EVAL && smp_pass) TAP_PASS_MAP[tap] <= 1'b1;
  end
`endif

endmodule
